// File: rtl/window_gen_nxn.sv
// window_gen_nxn: streaming NxN window generator over SIZE-1 cascaded line buffers,
// emitting one packed in-image window per accepted pixel once the neighbourhood is full.
module window_gen_nxn #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               in_valid,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               valid,
  output logic [SIZE*SIZE*DATA_WIDTH-1:0]    window,
  output logic                               frame_done
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH-1);
  localparam logic [CW-1:0] COL_FILL = CW'(SIZE-1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT-1);
  localparam logic [RW-1:0] ROW_FILL = RW'(SIZE-1);
  typedef enum logic [1:0] {FILL_LINES, FILL_COLS, EMIT} state_t;
  state_t state, state_next;
  logic [CW-1:0] col, col_next;
  logic [RW-1:0] row, row_next;
  logic col_wrap, last_px, emit;
  logic [DATA_WIDTH-1:0] lb [SIZE-1][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] cols [SIZE-1][SIZE];
  // taps[column][row]: registered columns plus the incoming column at SIZE-1
  logic [DATA_WIDTH-1:0] taps [SIZE][SIZE];
  always_comb begin
    col_wrap   = col == COL_LAST;
    last_px    = col_wrap && row == ROW_LAST;
    col_next   = col_wrap ? '0 : col + 1'b1;
    row_next   = !col_wrap ? row : (row == ROW_LAST ? '0 : row + 1'b1);
    emit       = in_valid && state == EMIT;
    state_next = !in_valid ? state :
                 row_next < ROW_FILL ? FILL_LINES :
                 col_next < COL_FILL ? FILL_COLS : EMIT;
  end
  always_comb begin
    for (int j = 0; j < SIZE-1; j++) taps[j] = cols[j];
    for (int i = 0; i < SIZE-1; i++) taps[SIZE-1][i] = lb[SIZE-2-i][col];
    taps[SIZE-1][SIZE-1] = in_data;
  end
  always_ff @(posedge clk)
    if (rstb && in_valid) begin
      lb[0][col] <= in_data;
      for (int k = 1; k < SIZE-1; k++) lb[k][col] <= lb[k-1][col];
    end
  always_ff @(posedge clk)
    if (!rstb) begin
      state      <= FILL_LINES;
      col        <= '0;
      row        <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
      window     <= '0;
      for (int j = 0; j < SIZE-1; j++)
        for (int i = 0; i < SIZE; i++) cols[j][i] <= '0;
    end else begin
      state      <= state_next;
      valid      <= emit;
      frame_done <= emit && last_px;
      if (in_valid) begin
        col <= col_next;
        row <= row_next;
        for (int j = 0; j < SIZE-1; j++) cols[j] <= taps[j+1];
      end
      if (emit)
        for (int j = 0; j < SIZE; j++)
          for (int i = 0; i < SIZE; i++) window[(SIZE*i+j)*DATA_WIDTH +: DATA_WIDTH] <= taps[j][i];
    end
endmodule

// File: tb/tb_window_gen_nxn.sv
// tb_window_gen_nxn: table vectors, random stream vs image-array model, reset and SIZE=5 cases.
module tb_window_gen_nxn;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstb, iv_a, iv_b, v_a, fd_a, v_b, fd_b;
  logic [7:0] d_a, d_b;
  logic [71:0] w_a;
  logic [199:0] w_b;
  window_gen_nxn #(.SIZE(3), .DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(4)) dut_a (
    .clk(clk), .rstb(rstb), .in_valid(iv_a), .in_data(d_a),
    .valid(v_a), .window(w_a), .frame_done(fd_a));
  window_gen_nxn #(.SIZE(5), .DATA_WIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(6)) dut_b (
    .clk(clk), .rstb(rstb), .in_valid(iv_b), .in_data(d_b),
    .valid(v_b), .window(w_b), .frame_done(fd_b));
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // reference: the image as received, windows cut from it by position
  logic [7:0] img [4][5];
  int mr = 0, mc = 0;
  logic e_v = 1'b0, e_fd = 1'b0;
  logic [71:0] e_w = '0;
  task automatic model(input logic v, input logic [7:0] d);
    e_v = 1'b0;
    e_fd = 1'b0;
    if (v) begin
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        e_v = 1'b1;
        e_fd = (mr == 3 && mc == 4);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) e_w[(3*i+j)*8 +: 8] = img[mr-2+i][mc-2+j];
      end
      mc++;
      if (mc == 5) begin
        mc = 0;
        mr = (mr + 1) % 4;
      end
    end
  endtask
  task automatic tick_a(input logic v, input logic [7:0] d);
    iv_a = v;
    d_a = d;
    @(posedge clk);
    #1;
    model(v, d);
  endtask
  task automatic step_a(input logic v, input logic [7:0] d, input string tag);
    tick_a(v, d);
    chk({tag, ".valid"}, 256'(v_a), 256'(e_v));
    chk({tag, ".frame_done"}, 256'(fd_a), 256'(e_fd));
    chk({tag, ".window"}, 256'(w_a), 256'(e_w));
  endtask
  task automatic do_reset();
    rstb = 1'b0;
    iv_a = 1'b0;
    iv_b = 1'b0;
    @(posedge clk);
    #1;
    rstb = 1'b1;
    mr = 0;
    mc = 0;
    e_v = 1'b0;
    e_fd = 1'b0;
    e_w = '0;
  endtask
  typedef struct {
    logic [7:0]  d;
    logic        ev;
    logic        efd;
    logic [71:0] ew;
  } vec_t;
  vec_t tbl [20];
  initial begin
    logic [71:0] hold;
    logic [199:0] bw;
    int nv, acc, r, c;
    hold = '0;
    for (int k = 0; k < 20; k++) begin
      r = k / 5;
      c = k % 5;
      tbl[k].d = 8'(r*16 + c);
      tbl[k].ev = r >= 2 && c >= 2;
      tbl[k].efd = r == 3 && c == 4;
      if (tbl[k].ev)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) hold[(3*i+j)*8 +: 8] = 8'((r-2+i)*16 + (c-2+j));
      tbl[k].ew = hold;
    end
    d_a = '0;
    d_b = '0;
    do_reset();
    chk("reset.valid_a", 256'(v_a), 256'(0));
    chk("reset.frame_done_a", 256'(fd_a), 256'(0));
    chk("reset.window_a", 256'(w_a), 256'(0));
    chk("reset.valid_b", 256'(v_b), 256'(0));
    // frame of row*16+col, continuous
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      tick_a(1'b1, tbl[k].d);
      nv += int'(v_a);
      chk($sformatf("tbl[%0d].valid", k), 256'(v_a), 256'(tbl[k].ev));
      chk($sformatf("tbl[%0d].frame_done", k), 256'(fd_a), 256'(tbl[k].efd));
      chk($sformatf("tbl[%0d].window", k), 256'(w_a), 256'(tbl[k].ew));
      if (k == 12) begin
        chk("first.window", 256'(w_a), 256'(72'h222120_121110_020100));
        chk("first.elem11", 256'(w_a[4*8 +: 8]), 256'(8'h11));
      end
      if (k == 17) chk("linewrap.window", 256'(w_a), 256'(72'h323130_222120_121110));
      if (k == 19) chk("last.window", 256'(w_a), 256'(72'h343332_242322_141312));
    end
    chk("tbl.count", 256'(nv), 256'(6));
    // random duty and data over three back-to-back frames
    acc = 0;
    while (acc < 60) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      step_a(v, 8'($urandom), "rand");
      acc += int'(v);
    end
    // two back-to-back frames; second offset by 0x80
    nv = 0;
    for (int k = 0; k < 40; k++) begin
      r = (k % 20) / 5;
      c = k % 5;
      step_a(1'b1, 8'((k >= 20 ? 8'h80 : 8'h00) + r*16 + c), "b2b");
      if (k >= 20 && k < 30) nv += int'(v_a);
      if (k == 32) chk("b2b.first2", 256'(w_a), 256'(72'hA2A1A0_929190_828180));
    end
    chk("b2b.no_valid_first_lines", 256'(nv), 256'(0));
    // mid-frame reset after pixel 0x23
    for (int k = 0; k < 14; k++) step_a(1'b1, 8'((k/5)*16 + k%5), "pre_rst");
    do_reset();
    chk("midrst.valid", 256'(v_a), 256'(0));
    chk("midrst.frame_done", 256'(fd_a), 256'(0));
    chk("midrst.window", 256'(w_a), 256'(0));
    for (int k = 0; k < 20; k++) begin
      step_a(1'b1, 8'(8'h40 + (k/5)*16 + k%5), "post_rst");
      if (k == 12) chk("post_rst.first", 256'(w_a), 256'(72'h626160_525150_424140));
    end
    iv_a = 1'b0;
    // SIZE=5 on an 8x6 frame
    nv = 0;
    bw = '0;
    for (int k = 0; k < 48; k++) begin
      r = k / 8;
      c = k % 8;
      iv_b = 1'b1;
      d_b = 8'(r*16 + c);
      @(posedge clk);
      #1;
      nv += int'(v_b);
      chk($sformatf("b[%0d].valid", k), 256'(v_b), 256'(r >= 4 && c >= 4));
      chk($sformatf("b[%0d].frame_done", k), 256'(fd_b), 256'(r == 5 && c == 7));
      if (r >= 4 && c >= 4) begin
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++) bw[(5*i+j)*8 +: 8] = 8'((r-4+i)*16 + (c-4+j));
        chk($sformatf("b[%0d].window", k), 256'(w_b), 256'(bw));
      end
      if (k == 36) chk("b.first.elem22", 256'(w_b[12*8 +: 8]), 256'(8'h22));
      if (k == 47) chk("b.last.elem44", 256'(w_b[24*8 +: 8]), 256'(8'h57));
    end
    iv_b = 1'b0;
    chk("b.count", 256'(nv), 256'(8));
    @(posedge clk);
    #1;
    chk("b.idle_valid", 256'(v_b), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/window_gen_nxn.md
Name: window_gen_nxn

Overview:
Streaming NxN window generator. It is the producer side of the median sorter's window interface. It accepts a raster-order pixel stream, one pixel per cycle when qualified, and buffers SIZE-1 previous lines. For every pixel position where a full NxN neighbourhood lies inside the image, it emits a packed window plus a valid strobe directly consumable by the sort stage.

Parameters:
SIZE, 3, window dimension N (odd, >=3)
DATA_WIDTH, 8, bits per pixel
IMG_WIDTH, 640, pixels per line (>= SIZE)
IMG_HEIGHT, 480, lines per frame (>= SIZE)

Ports:
clk  input  1  clock, all logic on rising edge
rstb  input  1  synchronous active-low reset
in_valid  input  1  in_data holds a valid pixel this cycle
in_data  input  DATA_WIDTH  pixel, raster order (left-to-right, top-to-bottom)
valid  output  1  window holds a complete in-image NxN window
window  output  SIZE*SIZE*DATA_WIDTH  packed window
frame_done  output  1  one-cycle pulse with the last window of a frame

Behaviour:
- Reset: when rstb=0 at a clock edge, the following are all cleared:
  - col counter, row counter and the window shift registers;
  - valid=0, window=0, frame_done=0.
  - Line-buffer contents are not cleared; they are don't-care because output gating covers them.
- Reset mid-frame: the partial frame is abandoned. The first in_valid pixel after rstb returns high is pixel (row 0, col 0).
- Pixel accept: every cycle with in_valid=1 consumes in_data. There is no backpressure. With in_valid=0, all state holds and valid=0, frame_done=0.
- Counters:
  - col runs 0..IMG_WIDTH-1 and wraps to 0, incrementing row.
  - row runs 0..IMG_HEIGHT-1 and wraps to 0 at end of frame.
  - Back-to-back frames need no idle cycles.
- Line buffers: SIZE-1 buffers, each IMG_WIDTH deep, cascaded. Each accepted pixel is written at index col; the value previously at that index shifts into the next buffer.
- Window column shift: each accept shifts SIZE column registers by one. The new column is {line buffer SIZE-2 output, ..., line buffer 0 output, in_data}, oldest line at top.
- State machine, per frame:
  - FILL_LINES: row < SIZE-1. No output.
  - FILL_COLS: row >= SIZE-1 and col < SIZE-1. No output; column registers preload.
  - EMIT: row >= SIZE-1 and col >= SIZE-1. Output is produced.
  - The state is re-evaluated each accept. At line wrap it returns to FILL_COLS; at frame wrap it returns to FILL_LINES.
- Output timing: the window for centre (r-(SIZE-1)/2, c-(SIZE-1)/2) is registered one cycle after accepting pixel (r, c) in EMIT. valid=1 for exactly that cycle.
- Window count: exactly (IMG_WIDTH-SIZE+1)*(IMG_HEIGHT-SIZE+1) windows per frame. No border padding.
- Packing:
  - Row i (i=0 is topmost/oldest line) occupies window[SIZE*i*DATA_WIDTH +: SIZE*DATA_WIDTH].
  - Within a row, element j (j=0 is leftmost/oldest column) occupies bits [j*DATA_WIDTH +: DATA_WIDTH].
  - So element (i,j) = window[(SIZE*i+j)*DATA_WIDTH +: DATA_WIDTH].
- window holds its last value while valid=0.
- frame_done=1 in the same cycle as valid for the window ending at pixel (IMG_HEIGHT-1, IMG_WIDTH-1). It is 0 otherwise.
- Column registers are not flushed at line wrap. FILL_COLS gating prevents previous-line pixels from appearing in any valid window.

Test Plan:
1. SIZE=3, IMG_WIDTH=5, IMG_HEIGHT=4, continuous in_valid, pixel = row*16+col.
   -> First valid occurs 1 cycle after accepting 0x22.
   -> Rows are {00,01,02}, {10,11,12}, {20,21,22}; element (1,1)=0x11.
   -> Exactly 6 valids per frame, the last being rows {12,13,14}, {22,23,24}, {32,33,34}, with frame_done=1.
2. Same frame, in_valid toggled randomly at 50% duty.
   -> Identical 6 windows in the same order.
   -> valid never asserts in a cycle following in_valid=0.
3. Line wrap: check no window mixes lines. After the window ending at 0x24, the next valid window ends at 0x32 with rows {10,11,12}, {20,21,22}, {30,31,32}.
4. Two frames back-to-back, second frame pixel = 0x80+row*16+col.
   -> Second frame's first window is {80,81,82}, {90,91,92}, {A0,A1,A2}.
   -> No valid is produced during its first 2 lines.
5. rstb=0 for one cycle after pixel 0x23 of frame 1.
   -> valid=0, frame_done=0, window=0 next cycle.
   -> A fresh frame then yields its first window at its pixel (2,2), with no stale data.
6. SIZE=5, IMG_WIDTH=8, IMG_HEIGHT=6.
   -> 8 windows total.
   -> First window element (2,2) = 0x22; last window element (4,4) = 0x57.
